aes_byte_ctrl: RTL and testbench

- Byte-serial sequencer that feeds a combinational 128-bit AES core (encrypt or decrypt) from 8-bit pins.
- Accumulates a 16-byte data block and a 16-byte key, then launches the core and waits a fixed settle time.
- Captures the 128-bit result and streams it out one byte at a time under a valid/ready handshake.
- Sits between the tile I/O pins and the AES encrypt/decrypt datapath.

---
 rtl/aes_byte_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_aes_byte_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_byte_ctrl.sv
// Byte-serial front end for a combinational AES-128 core: gathers a 16-byte block
// and key from 8-bit pins, launches the core, waits a fixed settle time, streams the result.
`timescale 1ns/1ps

module aes_byte_ctrl #(
    parameter int unsigned CORE_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [7:0]   din,
    input  logic         din_valid,
    input  logic         din_sel,
    input  logic         mode,
    input  logic         start,
    output logic [7:0]   dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] core_in,
    output logic [127:0] core_key,
    output logic         core_mode,
    input  logic [127:0] core_out
);

    localparam logic [3:0] LAT_LAST = 4'(CORE_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [127:0]   r_data;
    logic [127:0]   r_key;
    logic [127:0]   r_res;
    logic [4:0]     r_data_cnt;
    logic [4:0]     r_key_cnt;
    logic [3:0]     r_byte_cnt;
    logic [3:0]     r_wait;
    logic           r_mode;

    logic [127:0]   w_data_nxt;
    logic [127:0]   w_key_nxt;
    logic [127:0]   w_res_nxt;
    logic [4:0]     w_data_cnt_nxt;
    logic [4:0]     w_key_cnt_nxt;
    logic [3:0]     w_byte_cnt_nxt;
    logic [3:0]     w_wait_nxt;
    logic           w_mode_nxt;

    logic [7:0]     r_dout;
    logic           r_dout_valid;
    logic           r_busy;
    logic           r_done;
    logic           r_err;

    logic [7:0]     w_dout_nxt;
    logic           w_dout_valid_nxt;
    logic           w_busy_nxt;
    logic           w_done_nxt;
    logic           w_err_nxt;

    logic           w_full;
    logic           w_start_ok;
    logic           w_start_bad;
    logic           w_cap;
    logic           w_accept;
    logic           w_last;

    function automatic logic [4:0] sat_inc(input logic [4:0] cnt);
        logic [4:0] res;
        if (cnt == 5'd16) begin
            res = cnt;
        end else begin
            res = cnt + 5'd1;
        end
        return res;
    endfunction

    // Start is judged against the counts held before any same-cycle write.
    assign w_full      = (r_data_cnt == 5'd16) && (r_key_cnt == 5'd16);
    assign w_start_ok  = (r_state == ST_IDLE) && start && w_full;
    assign w_start_bad = (r_state == ST_IDLE) && start && !w_full;
    assign w_cap       = (r_state == ST_RUN) && (r_wait == LAT_LAST);
    assign w_accept    = (r_state == ST_OUT) && dout_ready;
    assign w_last      = w_accept && (r_byte_cnt == 4'd15);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (ena) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_cap) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_OUT: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: byte shifting, counters, settle timer, result capture
    always_comb begin
        w_data_nxt     = r_data;
        w_key_nxt      = r_key;
        w_res_nxt      = r_res;
        w_data_cnt_nxt = r_data_cnt;
        w_key_cnt_nxt  = r_key_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_wait_nxt     = r_wait;
        w_mode_nxt     = r_mode;
        case (r_state)
            ST_IDLE: begin
                if (din_valid && din_sel) begin
                    w_key_nxt     = {r_key[119:0], din};
                    w_key_cnt_nxt = sat_inc(r_key_cnt);
                end else if (din_valid) begin
                    w_data_nxt     = {r_data[119:0], din};
                    w_data_cnt_nxt = sat_inc(r_data_cnt);
                end else begin
                    w_data_nxt = r_data;
                end
                if (w_start_ok) begin
                    w_mode_nxt = mode;
                    w_wait_nxt = 4'd0;
                end else begin
                    w_mode_nxt = r_mode;
                end
            end
            ST_RUN: begin
                if (w_cap) begin
                    w_res_nxt      = core_out;
                    w_byte_cnt_nxt = 4'd0;
                end else begin
                    w_wait_nxt = r_wait + 4'd1;
                end
            end
            ST_OUT: begin
                if (w_accept) begin
                    w_res_nxt      = {r_res[119:0], 8'h00};
                    w_byte_cnt_nxt = r_byte_cnt + 4'd1;
                end else begin
                    w_res_nxt = r_res;
                end
                // Key is kept across blocks; only the data count restarts.
                if (w_last) begin
                    w_data_cnt_nxt = 5'd0;
                end else begin
                    w_data_cnt_nxt = r_data_cnt;
                end
            end
            default: begin
                w_res_nxt = r_res;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= 128'd0;
            r_key      <= 128'd0;
            r_res      <= 128'd0;
            r_data_cnt <= 5'd0;
            r_key_cnt  <= 5'd0;
            r_byte_cnt <= 4'd0;
            r_wait     <= 4'd0;
            r_mode     <= 1'b0;
        end else if (ena) begin
            r_data     <= w_data_nxt;
            r_key      <= w_key_nxt;
            r_res      <= w_res_nxt;
            r_data_cnt <= w_data_cnt_nxt;
            r_key_cnt  <= w_key_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_wait     <= w_wait_nxt;
            r_mode     <= w_mode_nxt;
        end
    end

    // Output decode, computed from next state so the pins come straight from flops
    always_comb begin
        w_dout_valid_nxt = 1'b0;
        w_dout_nxt       = 8'h00;
        if (w_state_nxt == ST_OUT) begin
            w_dout_valid_nxt = 1'b1;
            w_dout_nxt       = w_res_nxt[127:120];
        end else begin
            w_dout_valid_nxt = 1'b0;
            w_dout_nxt       = 8'h00;
        end
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = w_last;
        w_err_nxt  = w_start_bad;
    end

    // Output registers; done and err hold while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else if (ena) begin
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign core_in    = r_data;
    assign core_key   = r_key;
    assign core_mode  = r_mode;

endmodule

// File: tb/tb_aes_byte_ctrl.sv
// Bench for aes_byte_ctrl: a stub AES core answering the FIPS-197 known vectors,
// a transaction-level model checked every cycle, and literal known-answer checks.
`timescale 1ns/1ps

module tb_aes_byte_ctrl;

    localparam int LAT = 2;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic [7:0]   din;
    logic         din_valid;
    logic         din_sel;
    logic         mode;
    logic         start;
    logic [7:0]   dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] core_in;
    logic [127:0] core_key;
    logic         core_mode;
    logic [127:0] core_out;

    int n_err = 0;
    int n_chk = 0;

    aes_byte_ctrl #(.CORE_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din), .din_valid(din_valid),
        .din_sel(din_sel), .mode(mode), .start(start), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done),
        .err(err), .core_in(core_in), .core_key(core_key), .core_mode(core_mode),
        .core_out(core_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: exact AES answers for the known vectors, a cheap scramble otherwise.
    function automatic logic [127:0] core_stub(input logic [127:0] d, input logic [127:0] k,
                                               input logic m);
        if (!m && k == KEY && d == PT) return CT;
        else if (m && k == KEY && d == CT) return PT;
        else return {d[63:0], d[127:64]} ^ k ^ {128{m}};
    endfunction

    assign core_out = core_stub(core_in, core_key, core_mode);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [7:0] q[$]);
        logic [127:0] v = 128'd0;
        foreach (q[i]) v = (v << 8) | {120'd0, q[i]};
        return v;
    endfunction

    // Transaction-level model
    logic [7:0] m_dq[$];
    logic [7:0] m_kq[$];
    logic [7:0] m_oq[$];
    int         m_dcnt = 0;
    int         m_kcnt = 0;
    int         m_phase = 0;
    int         m_left = 0;
    logic       m_mode = 1'b0;
    logic       m_err = 1'b0;
    logic       m_done = 1'b0;

    initial begin : model
        logic         full;
        logic [127:0] v;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_dq.delete(); m_kq.delete(); m_oq.delete();
                m_dcnt = 0; m_kcnt = 0; m_phase = 0; m_left = 0;
                m_mode = 1'b0; m_err = 1'b0; m_done = 1'b0;
            end else if (ena) begin
                m_err = 1'b0;
                m_done = 1'b0;
                if (m_phase == 0) begin
                    full = (m_dcnt == 16) && (m_kcnt == 16);
                    if (din_valid && din_sel) begin
                        m_kq.push_back(din);
                        if (m_kq.size() > 16) void'(m_kq.pop_front());
                        if (m_kcnt < 16) m_kcnt++;
                    end else if (din_valid) begin
                        m_dq.push_back(din);
                        if (m_dq.size() > 16) void'(m_dq.pop_front());
                        if (m_dcnt < 16) m_dcnt++;
                    end
                    if (start && full) begin
                        m_mode = mode; m_phase = 1; m_left = LAT;
                    end else if (start) begin
                        m_err = 1'b1;
                    end
                end else if (m_phase == 1) begin
                    m_left--;
                    if (m_left == 0) begin
                        v = core_stub(pack(m_dq), pack(m_kq), m_mode);
                        for (int i = 0; i < 16; i++) m_oq.push_back(v[127-8*i -: 8]);
                        m_phase = 2;
                    end
                end else begin
                    if (dout_ready) begin
                        void'(m_oq.pop_front());
                        if (m_oq.size() == 0) begin
                            m_phase = 0; m_done = 1'b1; m_dcnt = 0;
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin : compare
        forever begin
            @(negedge clk);
            chk("dout_valid", dout_valid, m_phase == 2);
            chk("dout", dout, (m_phase == 2) ? m_oq[0] : 8'h00);
            chk("busy", busy, m_phase != 0);
            chk("done", done, m_done);
            chk("err", err, m_err);
            chk("core_in", core_in, pack(m_dq));
            chk("core_key", core_key, pack(m_kq));
            chk("core_mode", core_mode, m_mode);
        end
    end

    logic [7:0] rx_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic sel, input logic [7:0] b);
        din_valid = 1'b1; din_sel = sel; din = b;
        step();
        din_valid = 1'b0; din_sel = 1'b0; din = 8'h00;
    endtask

    task automatic load(input logic sel, input logic [127:0] v, input int nb);
        for (int i = 0; i < nb; i++) write_byte(sel, v[127-8*i -: 8]);
    endtask

    // Pulses start and counts steps until the first dout_valid (bounded).
    task automatic start_op(input logic m, output int n);
        start = 1'b1; mode = m;
        step();
        start = 1'b0; mode = 1'b0;
        n = 1;
        while (!dout_valid && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic drain(input int stall_after, input int nbytes, input logic [127:0] exp);
        int stalled = 0;
        int guard = 0;
        rx_q.delete();
        while (rx_q.size() < nbytes && guard < 200) begin
            if (stall_after >= 0 && rx_q.size() == stall_after && stalled < 5) begin
                dout_ready = 1'b0;
                stalled++;
                chk("bp_valid", dout_valid, 1'b1);
                chk("bp_hold", dout, exp[127-8*stall_after -: 8]);
            end else begin
                dout_ready = 1'b1;
                if (dout_valid) rx_q.push_back(dout);
            end
            step();
            guard++;
        end
        dout_ready = 1'b1;
        chk("rx_count", rx_q.size(), nbytes);
        for (int i = 0; i < nbytes && i < rx_q.size(); i++)
            chk("rx_byte", rx_q[i], exp[127-8*i -: 8]);
    endtask

    initial begin : stim
        int n;
        rst_n = 1'b0; ena = 1'b1; din = 8'h00; din_valid = 1'b0; din_sel = 1'b0;
        mode = 1'b0; start = 1'b0; dout_ready = 1'b1;
        repeat (3) step();
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_in", core_in, 128'd0);
        rst_n = 1'b1;
        step();

        // Encrypt known-answer vector
        load(1'b1, KEY, 16);
        load(1'b0, PT, 16);
        start_op(1'b0, n);
        chk("enc_latency", n, 3);
        drain(-1, 16, CT);
        chk("enc_done", done, 1'b1);
        chk("enc_valid_drop", dout_valid, 1'b0);
        step();
        chk("enc_done_once", done, 1'b0);

        // Key reuse, decrypt
        load(1'b0, CT, 16);
        start_op(1'b1, n);
        chk("dec_latency", n, 3);
        drain(-1, 16, PT);
        step();

        // Reject with 15 data bytes, then accept after the 16th, with backpressure
        load(1'b0, PT, 15);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rej_err", err, 1'b1);
        chk("rej_busy", busy, 1'b0);
        chk("rej_valid", dout_valid, 1'b0);
        step();
        chk("rej_err_pulse", err, 1'b0);
        write_byte(1'b0, 8'hff);
        start_op(1'b0, n);
        chk("acc_latency", n, 3);
        drain(3, 16, CT);
        step();

        // Freeze mid-RUN for 4 cycles
        load(1'b0, PT, 16);
        start = 1'b1;
        step();
        start = 1'b0;
        ena = 1'b0;
        repeat (4) step();
        chk("frz_busy", busy, 1'b1);
        ena = 1'b1;
        n = 5;
        while (!dout_valid && n < 60) begin
            step();
            n++;
        end
        chk("frz_latency", n, 7);

        // Reset asserted mid-OUT
        drain(-1, 5, CT);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_valid", dout_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_key", core_key, 128'd0);
        step();
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("post_rst_err", err, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
